// File: rtl/mem_wb_stage.sv
// MEM/WB stage register with writeback select and retire counter.
// Sub-word load extraction is built only when WB_SUBWORD_LOAD_EN is defined.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              stall,
    input  logic              flush,
    input  logic              m_valid,
    input  logic              m_reg_write,
    input  logic [1:0]        m_wb_sel,
    input  logic [2:0]        m_load_type,
    input  logic [1:0]        m_byte_off,
    input  logic [REG_AW-1:0] m_wreg,
    input  logic [DATA_W-1:0] m_alu_res,
    input  logic [DATA_W-1:0] m_mem_rdata,
    input  logic [DATA_W-1:0] m_link,
    output logic              RegWrite,
    output logic [REG_AW-1:0] Wreg_addr,
    output logic [DATA_W-1:0] Wdata,
    output logic              wb_valid,
    output logic [31:0]       retire_cnt
);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [REG_AW-1:0] wreg;
        logic [1:0]        wb_sel;
`ifdef WB_SUBWORD_LOAD_EN
        logic [2:0]        load_type;
        logic [1:0]        byte_off;
`endif
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] mem_rdata;
        logic [DATA_W-1:0] link;
    } wb_t;

    wb_t         r;
    wb_t         nxt;
    logic [31:0] cnt_q;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] sel_d;

    always_comb begin
        nxt           = '0;
        nxt.valid     = m_valid;
        nxt.reg_write = m_reg_write;
        nxt.wreg      = m_wreg;
        nxt.wb_sel    = m_wb_sel;
`ifdef WB_SUBWORD_LOAD_EN
        nxt.load_type = m_load_type;
        nxt.byte_off  = m_byte_off;
`endif
        nxt.alu_res   = m_alu_res;
        nxt.mem_rdata = m_mem_rdata;
        nxt.link      = m_link;
    end

    // Reset beats flush, flush beats stall; only the valid bit is cleared on flush.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r     <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            r.valid <= 1'b0;
        end else if (!stall) begin
            r <= nxt;
            if (m_valid)
                cnt_q <= cnt_q + 32'd1;
        end
    end

`ifdef WB_SUBWORD_LOAD_EN
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign ld_b = r.mem_rdata[8*r.byte_off +: 8];
    assign ld_h = r.byte_off[1] ? r.mem_rdata[31:16] : r.mem_rdata[15:0];

    always_comb begin
        case (r.load_type)
            3'b001:  ld_data = {{(DATA_W-8){ld_b[7]}}, ld_b};
            3'b010:  ld_data = {{(DATA_W-8){1'b0}}, ld_b};
            3'b011:  ld_data = {{(DATA_W-16){ld_h[15]}}, ld_h};
            3'b100:  ld_data = {{(DATA_W-16){1'b0}}, ld_h};
            default: ld_data = r.mem_rdata;
        endcase
    end
`else
    logic unused_ld;

    assign unused_ld = ^{m_load_type, m_byte_off};
    assign ld_data   = r.mem_rdata;
`endif

    always_comb begin
        case (r.wb_sel)
            2'b01:   sel_d = ld_data;
            2'b10:   sel_d = r.link;
            default: sel_d = r.alu_res;
        endcase
    end

    assign RegWrite   = r.valid & r.reg_write & (r.wreg != '0);
    assign Wreg_addr  = r.valid ? r.wreg : '0;
    assign Wdata      = r.valid ? sel_d : '0;
    assign wb_valid   = r.valid;
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed table, corner sequences, random vs model.
// Expected load data follows WB_SUBWORD_LOAD_EN when defined.
module tb_mem_wb_stage;

`ifdef WB_SUBWORD_LOAD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        stall, flush;
    logic        m_valid, m_reg_write;
    logic [1:0]  m_wb_sel;
    logic [2:0]  m_load_type;
    logic [1:0]  m_byte_off;
    logic [4:0]  m_wreg;
    logic [31:0] m_alu_res, m_mem_rdata, m_link;
    logic        RegWrite;
    logic [4:0]  Wreg_addr;
    logic [31:0] Wdata;
    logic        wb_valid;
    logic [31:0] retire_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mem_wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .CLK(CLK), .RST_N(RST_N), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_reg_write(m_reg_write),
        .m_wb_sel(m_wb_sel), .m_load_type(m_load_type),
        .m_byte_off(m_byte_off), .m_wreg(m_wreg),
        .m_alu_res(m_alu_res), .m_mem_rdata(m_mem_rdata),
        .m_link(m_link), .RegWrite(RegWrite), .Wreg_addr(Wreg_addr),
        .Wdata(Wdata), .wb_valid(wb_valid), .retire_cnt(retire_cnt)
    );

    // Reference model: the instruction currently sitting in WB plus retire count.
    typedef struct {
        logic        v, rw;
        logic [4:0]  wreg;
        logic [1:0]  sel;
        logic [2:0]  lt;
        logic [1:0]  off;
        logic [31:0] alu, mem, link;
    } ins_t;

    ins_t        held;
    logic [31:0] mcnt;

    function automatic logic [31:0] load_val(ins_t i);
        logic [31:0] b, h;
        b = (i.mem >> (8 * i.off)) & 32'hFF;
        h = (i.mem >> (16 * i.off[1])) & 32'hFFFF;
        if (!SUB) return i.mem;
        case (i.lt)
            3'd1:    return (b >= 128) ? b - 32'd256 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    return h;
            default: return i.mem;
        endcase
    endfunction

    function automatic logic [31:0] exp_data(ins_t i);
        if (!i.v) return 32'd0;
        if (i.sel == 2'd1) return load_val(i);
        if (i.sel == 2'd2) return i.link;
        return i.alu;
    endfunction

    function automatic ins_t cur_in();
        ins_t i;
        i.v = m_valid; i.rw = m_reg_write; i.wreg = m_wreg;
        i.sel = m_wb_sel; i.lt = m_load_type; i.off = m_byte_off;
        i.alu = m_alu_res; i.mem = m_mem_rdata; i.link = m_link;
        return i;
    endfunction

    task automatic tick();
        @(posedge CLK);
        if (!RST_N) begin
            held = '{default: '0};
            mcnt = 32'd0;
        end else if (flush) begin
            held.v = 1'b0;
        end else if (!stall) begin
            if (m_valid) mcnt = mcnt + 32'd1;
            held = cur_in();
        end
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_model(string tag);
        chk({tag, ".RegWrite"}, 32'(RegWrite),
            32'(held.v && held.rw && held.wreg != 0));
        chk({tag, ".Wreg_addr"}, 32'(Wreg_addr), held.v ? 32'(held.wreg) : 0);
        chk({tag, ".Wdata"}, Wdata, exp_data(held));
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(held.v));
        chk({tag, ".retire_cnt"}, retire_cnt, mcnt);
    endtask

    task automatic set_in(logic v, logic rw, logic [4:0] w, logic [1:0] s,
                          logic [2:0] lt, logic [1:0] off, logic [31:0] alu,
                          logic [31:0] mem, logic [31:0] lk);
        m_valid = v; m_reg_write = rw; m_wreg = w; m_wb_sel = s;
        m_load_type = lt; m_byte_off = off;
        m_alu_res = alu; m_mem_rdata = mem; m_link = lk;
    endtask

    task automatic rand_in();
        set_in(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom),
               3'($urandom_range(0, 7)), 2'($urandom), $urandom,
               $urandom, $urandom);
    endtask

    typedef struct {
        logic        v, rw;
        logic [4:0]  wreg;
        logic [1:0]  sel;
        logic [2:0]  lt;
        logic [1:0]  off;
        logic [31:0] alu, mem, link;
        logic        e_rw;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
    } vec_t;

    localparam logic [31:0] MW = 32'h80FF7F01;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 1, 9, 0, 0, 0, 32'h12345678, MW, 0, 1, 9, 32'h12345678};
        tbl[1] = '{1, 1, 5, 1, 1, 3, 0, MW, 0, 1, 5, SUB ? 32'hFFFFFF80 : MW};
        tbl[2] = '{1, 1, 6, 1, 2, 2, 0, MW, 0, 1, 6, SUB ? 32'h000000FF : MW};
        tbl[3] = '{1, 1, 7, 1, 3, 2, 0, MW, 0, 1, 7, SUB ? 32'hFFFF80FF : MW};
        tbl[4] = '{1, 1, 8, 1, 4, 1, 0, MW, 0, 1, 8, SUB ? 32'h00007F01 : MW};
        tbl[5] = '{1, 1, 0, 0, 0, 0, 32'hAAAA, MW, 0, 0, 0, 32'hAAAA};
        tbl[6] = '{0, 1, 3, 0, 0, 0, 32'h5, MW, 0, 0, 0, 0};
        tbl[7] = '{1, 0, 4, 3, 0, 0, 32'hDEAD0001, MW, 0, 0, 4, 32'hDEAD0001};
        tbl[8] = '{1, 1, 31, 2, 0, 0, 0, MW, 32'h00400010, 1, 31, 32'h00400010};
        tbl[9] = '{1, 1, 2, 1, 0, 3, 0, MW, 0, 1, 2, MW};

        held = '{default: '0};
        mcnt = 32'd0;
        stall = 0; flush = 0;

        // Reset with a valid instruction on the inputs
        RST_N = 0;
        set_in(1, 1, 8, 0, 0, 0, 32'hCAFE, 0, 0);
        tick();
        RST_N = 1;
        chk("rst.RegWrite", 32'(RegWrite), 0);
        chk("rst.Wdata", Wdata, 0);
        chk("rst.retire_cnt", retire_cnt, 0);
        chk("rst.wb_valid", 32'(wb_valid), 0);
        chk("rst.Wreg_addr", 32'(Wreg_addr), 0);

        for (int k = 0; k < 10; k++) begin
            set_in(tbl[k].v, tbl[k].rw, tbl[k].wreg, tbl[k].sel, tbl[k].lt,
                   tbl[k].off, tbl[k].alu, tbl[k].mem, tbl[k].link);
            tick();
            chk($sformatf("vec%0d.RegWrite", k), 32'(RegWrite), 32'(tbl[k].e_rw));
            chk($sformatf("vec%0d.Wreg_addr", k), 32'(Wreg_addr), 32'(tbl[k].e_addr));
            chk($sformatf("vec%0d.Wdata", k), Wdata, tbl[k].e_data);
            chk($sformatf("vec%0d.retire_cnt", k), retire_cnt, mcnt);
        end

        // jal captured, then held across a 3-cycle stall
        set_in(1, 1, 31, 2, 0, 0, 32'h1, 32'h2, 32'h00400010);
        tick();
        chk("jal.Wdata", Wdata, 32'h00400010);
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            rand_in();
            tick();
            chk($sformatf("stall%0d.Wdata", k), Wdata, 32'h00400010);
            chk($sformatf("stall%0d.Wreg_addr", k), 32'(Wreg_addr), 31);
            chk($sformatf("stall%0d.retire_cnt", k), retire_cnt, mcnt);
        end
        flush = 1;
        tick();
        chk("flush.wb_valid", 32'(wb_valid), 0);
        chk("flush.RegWrite", 32'(RegWrite), 0);
        chk("flush.Wdata", Wdata, 0);
        chk("flush.retire_cnt", retire_cnt, mcnt);
        stall = 0; flush = 0;

        // Reset while stalled discards the held instruction
        set_in(1, 1, 12, 0, 0, 0, 32'h77, 0, 0);
        tick();
        stall = 1; RST_N = 0;
        tick();
        RST_N = 1; stall = 0;
        chk("rststall.wb_valid", 32'(wb_valid), 0);
        chk("rststall.retire_cnt", retire_cnt, 0);
        chk("rststall.Wdata", Wdata, 0);

        // Counter wrap through a backdoor preload
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        force dut.cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.cnt_q;
        mcnt = 32'hFFFFFFFF;
        chk("wrap.preload", retire_cnt, 32'hFFFFFFFF);
        set_in(1, 1, 3, 0, 0, 0, 32'h9, 0, 0);
        tick();
        chk("wrap.retire_cnt", retire_cnt, 0);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            rand_in();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            RST_N = ($urandom_range(0, 49) != 0);
            tick();
            chk_model($sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
